aes_output_buffer: RTL and testbench

//  - Downstream stage of the AES encryption pipeline: captures each finished 128-bit ciphertext block
//    (data_done & data_output) into a DEPTH-entry FIFO.
//  - Drives is_full back to the encryption core, which freezes its pipeline while full; no block is lost.
//  - Host side drains blocks as four 32-bit words, most-significant word first.

---
 rtl/aes_output_buffer_if.sv | 39 +++
 rtl/aes_output_buffer.sv | 112 +++++++++++
 tb/tb_aes_output_buffer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_output_buffer_if.sv
// Host/core-facing signals of the AES ciphertext output buffer.
// The rd_err underrun flag exists only when AES_OUTBUF_UNDERRUN_EN is defined.
interface aes_output_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic           data_done;
  logic [127:0]   data_output;
  logic           is_full;
  logic           rd_en;
  logic [31:0]    rd_data;
  logic           rd_valid;
  logic [CW-1:0]  block_count;

`ifdef AES_OUTBUF_UNDERRUN_EN
  logic           rd_err;

  modport master (
    output data_done, data_output, rd_en,
    input  is_full, rd_data, rd_valid, block_count, rd_err
  );

  modport slave (
    input  data_done, data_output, rd_en,
    output is_full, rd_data, rd_valid, block_count, rd_err
  );
`else
  modport master (
    output data_done, data_output, rd_en,
    input  is_full, rd_data, rd_valid, block_count
  );

  modport slave (
    input  data_done, data_output, rd_en,
    output is_full, rd_data, rd_valid, block_count
  );
`endif
endinterface

// File: rtl/aes_output_buffer.sv
// DEPTH-entry FIFO of 128-bit AES ciphertext blocks, drained as 32-bit words MSW first.
// Optional sticky underrun flag rd_err when AES_OUTBUF_UNDERRUN_EN is defined.
module aes_output_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear,
  aes_output_buffer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [1:0]  LAST_WORD = 2'd3;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    word_idx;
  logic [CW-1:0] count;

  logic          full_c;
  logic          valid_c;
  logic          wr_c;
  logic          rd_c;
  logic          pop_c;
  logic [127:0]  head_c;
  logic [31:0]   word_c;

  // Status is decoded from the count register only, so is_full never depends on rd_en.
  always_comb begin
    full_c  = (count == CW'(DEPTH));
    valid_c = (count != '0);
    wr_c    = bus.data_done & ~full_c;
    rd_c    = bus.rd_en & valid_c;
    pop_c   = rd_c & (word_idx == LAST_WORD);
  end

  // Block storage; a block arriving alongside clear is dropped.
  always_ff @(posedge clk) begin
    if (wr_c && !clear) begin
      mem[wr_ptr] <= bus.data_output;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_idx <= '0;
      count    <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_idx <= '0;
      count    <= '0;
    end else begin
      if (wr_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_c) begin
        word_idx <= word_idx + 2'd1;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head word select, forced to zero while empty.
  always_comb begin
    head_c = mem[rd_ptr];
    word_c = '0;
    case (word_idx)
      2'd0:    word_c = head_c[127:96];
      2'd1:    word_c = head_c[95:64];
      2'd2:    word_c = head_c[63:32];
      default: word_c = head_c[31:0];
    endcase
    if (!valid_c) begin
      word_c = '0;
    end
  end

  assign bus.is_full     = full_c;
  assign bus.rd_valid    = valid_c;
  assign bus.rd_data     = word_c;
  assign bus.block_count = count;

`ifdef AES_OUTBUF_UNDERRUN_EN
  logic rd_err;

  // Sticky underrun flag; clear takes priority over a same-cycle underrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_err <= 1'b0;
    end else if (clear) begin
      rd_err <= 1'b0;
    end else if (bus.rd_en && !valid_c) begin
      rd_err <= 1'b1;
    end
  end

  assign bus.rd_err = rd_err;
`endif

endmodule

// File: tb/tb_aes_output_buffer.sv
// Self-checking bench for aes_output_buffer against a queue-of-blocks reference model.
module tb_aes_output_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic clk;
  logic n_rst;
  logic clear;

  aes_output_buffer_if #(.DEPTH(DEPTH)) bus ();

  aes_output_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: stored blocks in arrival order plus index of next word of the head block.
  logic [127:0] mq[$];
  int           widx = 0;
`ifdef AES_OUTBUF_UNDERRUN_EN
  bit           m_err = 0;
`endif

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int w);
    return 32'(blk >> (96 - 32 * w));
  endfunction

  function automatic logic [31:0] exp_word();
    if (mq.size() == 0) return 32'h0;
    return word_of(mq[0], widx);
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Applies one cycle of stimulus from a negedge, advances the model at the posedge.
  task automatic drive(input logic done, input logic [127:0] d, input logic rden, input logic clr);
    bit m_full;
    bit m_valid;
    bus.data_done   = done;
    bus.data_output = d;
    bus.rd_en       = rden;
    clear           = clr;
    m_full  = (mq.size() == DEPTH);
    m_valid = (mq.size() != 0);
    @(posedge clk);
    if (clr) begin
      mq.delete();
      widx = 0;
`ifdef AES_OUTBUF_UNDERRUN_EN
      m_err = 0;
`endif
    end else begin
`ifdef AES_OUTBUF_UNDERRUN_EN
      if (rden && !m_valid) m_err = 1;
`endif
      if (rden && m_valid) begin
        if (widx == 3) begin
          void'(mq.pop_front());
          widx = 0;
        end else begin
          widx++;
        end
      end
      if (done && !m_full) mq.push_back(d);
    end
    @(negedge clk);
    bus.data_done = 1'b0;
    bus.rd_en     = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic drain();
    while (mq.size() != 0) drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    compared++; if (bus.block_count !== CW'(0)) begin mismatched++; $display("FAIL reset_count act=%0d exp=0", bus.block_count); end
    compared++; if (bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid act=%b exp=0", bus.rd_valid); end
    compared++; if (bus.is_full !== 1'b0) begin mismatched++; $display("FAIL reset_full act=%b exp=0", bus.is_full); end
    compared++; if (bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL reset_data act=%h exp=0", bus.rd_data); end
`ifdef AES_OUTBUF_UNDERRUN_EN
    compared++; if (bus.rd_err !== 1'b0) begin mismatched++; $display("FAIL reset_err act=%b exp=0", bus.rd_err); end
`endif
  endtask

  task automatic test_single_block();
    logic [31:0] ev [4];
    ev = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};
    drive(1'b1, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 1'b0);
    compared++; if (bus.rd_valid !== 1'b1) begin mismatched++; $display("FAIL single_valid act=%b exp=1", bus.rd_valid); end
    compared++; if (bus.block_count !== CW'(1)) begin mismatched++; $display("FAIL single_count act=%0d exp=1", bus.block_count); end
    for (int w = 0; w < 4; w++) begin
      compared++; if (bus.rd_data !== ev[w]) begin mismatched++; $display("FAIL single_word%0d act=%h exp=%h", w, bus.rd_data, ev[w]); end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    compared++; if (bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL single_empty_valid act=%b exp=0", bus.rd_valid); end
    compared++; if (bus.block_count !== CW'(0)) begin mismatched++; $display("FAIL single_empty_count act=%0d exp=0", bus.block_count); end
  endtask

  task automatic test_fill();
    logic [127:0] b [5];
    for (int i = 0; i < 5; i++) b[i] = rand_blk();
    for (int i = 0; i < 4; i++) drive(1'b1, b[i], 1'b0, 1'b0);
    compared++; if (bus.is_full !== 1'b1) begin mismatched++; $display("FAIL fill_full act=%b exp=1", bus.is_full); end
    compared++; if (bus.block_count !== CW'(4)) begin mismatched++; $display("FAIL fill_count act=%0d exp=4", bus.block_count); end
    for (int w = 0; w < 4; w++) begin
      compared++; if (bus.rd_data !== word_of(b[0], w)) begin mismatched++; $display("FAIL fill_b1_word%0d act=%h exp=%h", w, bus.rd_data, word_of(b[0], w)); end
      drive(1'b1, b[4], 1'b1, 1'b0);
    end
    compared++; if (bus.block_count !== CW'(3)) begin mismatched++; $display("FAIL fill_hold_count act=%0d exp=3", bus.block_count); end
    drive(1'b1, b[4], 1'b0, 1'b0);
    compared++; if (bus.block_count !== CW'(4)) begin mismatched++; $display("FAIL fill_capture_count act=%0d exp=4", bus.block_count); end
    for (int k = 1; k < 5; k++) begin
      for (int w = 0; w < 4; w++) begin
        compared++; if (bus.rd_data !== word_of(b[k], w)) begin mismatched++; $display("FAIL fill_order_b%0d_w%0d act=%h exp=%h", k + 1, w, bus.rd_data, word_of(b[k], w)); end
        drive(1'b0, '0, 1'b1, 1'b0);
      end
    end
    compared++; if (bus.block_count !== CW'(0)) begin mismatched++; $display("FAIL fill_nodup_count act=%0d exp=0", bus.block_count); end
  endtask

  task automatic test_simultaneous();
    logic [127:0] b [3];
    for (int i = 0; i < 3; i++) b[i] = rand_blk();
    drive(1'b1, b[0], 1'b0, 1'b0);
    drive(1'b1, b[1], 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, b[2], 1'b1, 1'b0);
    compared++; if (bus.block_count !== CW'(2)) begin mismatched++; $display("FAIL simul_count act=%0d exp=2", bus.block_count); end
    for (int k = 1; k < 3; k++) begin
      for (int w = 0; w < 4; w++) begin
        compared++; if (bus.rd_data !== word_of(b[k], w)) begin mismatched++; $display("FAIL simul_order_b%0d_w%0d act=%h exp=%h", k, w, bus.rd_data, word_of(b[k], w)); end
        drive(1'b0, '0, 1'b1, 1'b0);
      end
    end
    compared++; if (bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL simul_empty act=%b exp=0", bus.rd_valid); end
  endtask

  task automatic test_full_final_read();
    logic [127:0] b [5];
    for (int i = 0; i < 5; i++) b[i] = rand_blk();
    for (int i = 0; i < 4; i++) drive(1'b1, b[i], 1'b0, 1'b0);
    repeat (3) drive(1'b1, b[4], 1'b1, 1'b0);
    drive(1'b1, b[4], 1'b1, 1'b0);
    compared++; if (bus.block_count !== CW'(3)) begin mismatched++; $display("FAIL fullrd_count3 act=%0d exp=3", bus.block_count); end
    compared++; if (bus.is_full !== 1'b0) begin mismatched++; $display("FAIL fullrd_notfull act=%b exp=0", bus.is_full); end
    drive(1'b1, b[4], 1'b0, 1'b0);
    compared++; if (bus.block_count !== CW'(4)) begin mismatched++; $display("FAIL fullrd_count4 act=%0d exp=4", bus.block_count); end
    compared++; if (bus.rd_data !== word_of(b[1], 0)) begin mismatched++; $display("FAIL fullrd_head act=%h exp=%h", bus.rd_data, word_of(b[1], 0)); end
    drain();
  endtask

  task automatic test_clear();
    logic [127:0] bn;
    bn = rand_blk();
    for (int i = 0; i < 3; i++) drive(1'b1, rand_blk(), 1'b0, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, rand_blk(), 1'b0, 1'b1);
    compared++; if (bus.block_count !== CW'(0)) begin mismatched++; $display("FAIL clear_count act=%0d exp=0", bus.block_count); end
    compared++; if (bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL clear_valid act=%b exp=0", bus.rd_valid); end
    compared++; if (bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL clear_data act=%h exp=0", bus.rd_data); end
    compared++; if (bus.is_full !== 1'b0) begin mismatched++; $display("FAIL clear_full act=%b exp=0", bus.is_full); end
    drive(1'b1, bn, 1'b0, 1'b0);
    compared++; if (bus.rd_data !== bn[127:96]) begin mismatched++; $display("FAIL clear_newword0 act=%h exp=%h", bus.rd_data, bn[127:96]); end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [127:0] bn;
    bn = rand_blk();
    drive(1'b1, rand_blk(), 1'b0, 1'b0);
    drive(1'b1, rand_blk(), 1'b0, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    compared++; if (bus.block_count !== CW'(0)) begin mismatched++; $display("FAIL rstmid_count act=%0d exp=0", bus.block_count); end
    compared++; if (bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL rstmid_data act=%h exp=0", bus.rd_data); end
    @(negedge clk);
    n_rst = 1'b1;
    mq.delete();
    widx = 0;
`ifdef AES_OUTBUF_UNDERRUN_EN
    m_err = 0;
`endif
    drive(1'b1, bn, 1'b0, 1'b0);
    compared++; if (bus.rd_data !== bn[127:96]) begin mismatched++; $display("FAIL rstmid_word0 act=%h exp=%h", bus.rd_data, bn[127:96]); end
    drain();
  endtask

  task automatic test_underrun();
    logic [127:0] b;
    b = rand_blk();
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
`ifdef AES_OUTBUF_UNDERRUN_EN
    compared++; if (bus.rd_err !== 1'b1) begin mismatched++; $display("FAIL underrun_set act=%b exp=1", bus.rd_err); end
    drive(1'b1, b, 1'b0, 1'b0);
    compared++; if (bus.rd_err !== 1'b1) begin mismatched++; $display("FAIL underrun_sticky act=%b exp=1", bus.rd_err); end
`else
    compared++; if (bus.block_count !== CW'(0)) begin mismatched++; $display("FAIL underrun_count act=%0d exp=0", bus.block_count); end
    compared++; if (bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL underrun_valid act=%b exp=0", bus.rd_valid); end
    drive(1'b1, b, 1'b0, 1'b0);
`endif
    compared++; if (bus.block_count !== CW'(1)) begin mismatched++; $display("FAIL underrun_wrcount act=%0d exp=1", bus.block_count); end
    compared++; if (bus.rd_data !== b[127:96]) begin mismatched++; $display("FAIL underrun_word0 act=%h exp=%h", bus.rd_data, b[127:96]); end
    drive(1'b0, '0, 1'b0, 1'b1);
`ifdef AES_OUTBUF_UNDERRUN_EN
    compared++; if (bus.rd_err !== 1'b0) begin mismatched++; $display("FAIL underrun_clear act=%b exp=0", bus.rd_err); end
    drive(1'b0, '0, 1'b1, 1'b1);
    compared++; if (bus.rd_err !== 1'b0) begin mismatched++; $display("FAIL underrun_clearwins act=%b exp=0", bus.rd_err); end
`endif
  endtask

  task automatic test_random();
    logic [127:0] pend;
    bit           pend_v;
    int           rd_pct;
    bit           dn;
    bit           rd;
    bit           cl;
    pend_v = 0;
    pend   = '0;
    for (int i = 0; i < 800; i++) begin
      case (i / 200)
        0:       rd_pct = 20;
        1:       rd_pct = 50;
        2:       rd_pct = 80;
        default: rd_pct = 97;
      endcase
      compared++; if (bus.rd_data !== exp_word()) begin mismatched++; $display("FAIL rand_data cyc=%0d act=%h exp=%h", i, bus.rd_data, exp_word()); end
      compared++; if (bus.block_count !== CW'(mq.size())) begin mismatched++; $display("FAIL rand_count cyc=%0d act=%0d exp=%0d", i, bus.block_count, mq.size()); end
      compared++; if (bus.is_full !== (mq.size() == DEPTH)) begin mismatched++; $display("FAIL rand_full cyc=%0d act=%b exp=%b", i, bus.is_full, mq.size() == DEPTH); end
      compared++; if (bus.rd_valid !== (mq.size() != 0)) begin mismatched++; $display("FAIL rand_valid cyc=%0d act=%b exp=%b", i, bus.rd_valid, mq.size() != 0); end
`ifdef AES_OUTBUF_UNDERRUN_EN
      compared++; if (bus.rd_err !== m_err) begin mismatched++; $display("FAIL rand_err cyc=%0d act=%b exp=%b", i, bus.rd_err, m_err); end
`endif
      if (!pend_v && ($urandom_range(99) < 60)) begin
        pend   = rand_blk();
        pend_v = 1;
      end
      dn = pend_v;
      rd = ($urandom_range(99) < rd_pct);
      cl = ($urandom_range(127) == 0);
      if (dn && (cl || mq.size() != DEPTH)) pend_v = 0;
      drive(dn, pend, rd, cl);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk             = 1'b0;
    n_rst           = 1'b0;
    clear           = 1'b0;
    bus.data_done   = 1'b0;
    bus.data_output = '0;
    bus.rd_en       = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    n_rst = 1'b1;
    @(negedge clk);
    test_single_block();
    test_fill();
    test_simultaneous();
    test_full_final_read();
    test_clear();
    test_reset_mid();
    test_underrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
